// File: rtl/i2c_rx_frontend_if.sv
// i2c_rx_frontend_if: raw I2C pins in, conditioned levels/strobes and received bytes out.
interface i2c_rx_frontend_if;
    logic       scl_in;
    logic       sda_in;
    logic       scl;
    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       bus_busy;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       ack_slot;
    logic       rx_ack;
    logic       ack_valid;
    logic [3:0] bit_cnt;
    logic       bus_err;

    modport master (
        output scl_in, sda_in,
        input  scl, sda, scl_rise, scl_fall, start_det, stop_det, bus_busy,
        input  rx_byte, rx_valid, ack_slot, rx_ack, ack_valid, bit_cnt, bus_err
    );

    modport slave (
        input  scl_in, sda_in,
        output scl, sda, scl_rise, scl_fall, start_det, stop_det, bus_busy,
        output rx_byte, rx_valid, ack_slot, rx_ack, ack_valid, bit_cnt, bus_err
    );
endinterface

// File: rtl/i2c_rx_frontend.sv
// i2c_rx_frontend: pin synchronizer, glitch filter, SCL edge / START / STOP detection and byte deserialiser.
// Define I2C_GLITCH_FILTER_EN to enable the FILT_LEN-clock glitch filter; otherwise the filter is a single register.
module i2c_rx_frontend #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    i2c_rx_frontend_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("FILT_LEN must be in 1..15");
    end

    // Bit 0 carries SCL, bit 1 carries SDA throughout the conditioning pipeline.
    logic [1:0] sync1, sync2, filt, filt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {bus.sda_in, bus.scl_in};
            sync2 <= sync1;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [3:0] cnt [2];

    // Level follows the synchronized line only after FILT_LEN consecutive disagreeing clocks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt <= '1;
            for (int i = 0; i < 2; i++) cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= 4'd0;
                end else if (cnt[i] == 4'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= 4'd0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) filt <= '1;
        else      filt <= sync2;
    end
`endif

    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shadow, shadow_n, rx_byte, rx_byte_n;
    logic       rx_valid, rx_valid_n, ack_slot, ack_slot_n;
    logic       rx_ack, rx_ack_n, ack_valid, ack_valid_n, bus_busy, bus_busy_n;
    logic       scl_rise, scl_fall, start_det, stop_det, bus_err;
    logic       rise_c, fall_c, start_c, stop_c, err_c;

    // SDA edges count as strobes only while SCL was high on both samples.
    always_comb begin
        rise_c  = filt[0] & ~filt_d[0];
        fall_c  = ~filt[0] & filt_d[0];
        start_c = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
        stop_c  = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];
        err_c   = (start_c | stop_c) & ((state == BITS && bit_cnt != 4'd0) || state == ACK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_d    <= '1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            filt_d    <= filt;
            scl_rise  <= rise_c;
            scl_fall  <= fall_c;
            start_det <= start_c;
            stop_det  <= stop_c;
            bus_err   <= err_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shadow    <= 8'h00;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            ack_slot  <= 1'b0;
            rx_ack    <= 1'b1;
            ack_valid <= 1'b0;
            bus_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shadow    <= shadow_n;
            rx_byte   <= rx_byte_n;
            rx_valid  <= rx_valid_n;
            ack_slot  <= ack_slot_n;
            rx_ack    <= rx_ack_n;
            ack_valid <= ack_valid_n;
            bus_busy  <= bus_busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shadow_n    = shadow;
        rx_byte_n   = rx_byte;
        rx_valid_n  = 1'b0;
        ack_slot_n  = ack_slot;
        rx_ack_n    = rx_ack;
        ack_valid_n = 1'b0;
        bus_busy_n  = bus_busy;
        if (stop_det) begin
            state_n    = IDLE;
            bus_busy_n = 1'b0;
            bit_cnt_n  = 4'd0;
            ack_slot_n = 1'b0;
        end else if (start_det) begin
            state_n    = BITS;
            bus_busy_n = 1'b1;
            bit_cnt_n  = 4'd0;
            ack_slot_n = 1'b0;
        end else if (scl_rise) begin
            case (state)
                BITS: begin
                    shadow_n  = {shadow[6:0], filt[1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        rx_byte_n  = {shadow[6:0], filt[1]};
                        rx_valid_n = 1'b1;
                        ack_slot_n = 1'b1;
                        state_n    = ACK;
                    end
                end
                ACK: begin
                    rx_ack_n    = filt[1];
                    ack_valid_n = 1'b1;
                    ack_slot_n  = 1'b0;
                    bit_cnt_n   = 4'd0;
                    state_n     = BITS;
                end
                default: ;
            endcase
        end
    end

    assign bus.scl       = filt[0];
    assign bus.sda       = filt[1];
    assign bus.scl_rise  = scl_rise;
    assign bus.scl_fall  = scl_fall;
    assign bus.start_det = start_det;
    assign bus.stop_det  = stop_det;
    assign bus.bus_busy  = bus_busy;
    assign bus.rx_byte   = rx_byte;
    assign bus.rx_valid  = rx_valid;
    assign bus.ack_slot  = ack_slot;
    assign bus.rx_ack    = rx_ack;
    assign bus.ack_valid = ack_valid;
    assign bus.bit_cnt   = bit_cnt;
    assign bus.bus_err   = bus_err;
endmodule

// File: tb/tb_i2c_rx_frontend.sv
// tb_i2c_rx_frontend: pin-level I2C stimulus, bus-event reference model and scoreboard for i2c_rx_frontend.
module tb_i2c_rx_frontend;
    localparam int unsigned H = 8;
`ifdef I2C_GLITCH_FILTER_EN
    localparam int  START_LAT   = 6;
    localparam bit  SHORT_PASSES = 1'b0;
`else
    localparam int  START_LAT   = 4;
    localparam bit  SHORT_PASSES = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_rx_frontend_if bus();
    i2c_rx_frontend #(.FILT_LEN(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef enum int {EV_START, EV_STOP, EV_BYTE, EV_ACK} ev_kind_t;
    typedef struct { ev_kind_t kind; logic [7:0] val; } ev_t;
    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Bus-event model: every SCL rise is a bit, SDA edges under high SCL are START/STOP.
    bit m_busy = 1'b0;
    int m_pos  = 0;
    int m_byte = 0;

    function automatic void push(input ev_kind_t k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = 8'(v);
        exp_q.push_back(e);
    endfunction

    function void m_start();
        push(EV_START, (m_busy && m_pos != 0) ? 1 : 0);
        m_busy = 1'b1; m_pos = 0; m_byte = 0;
    endfunction

    function void m_stop();
        push(EV_STOP, (m_busy && m_pos != 0) ? 1 : 0);
        m_busy = 1'b0; m_pos = 0; m_byte = 0;
    endfunction

    function void m_bit(input int v);
        if (!m_busy) return;
        m_pos++;
        if (m_pos <= 8) m_byte = (m_byte * 2 + v) % 256;
        if (m_pos == 8) push(EV_BYTE, m_byte);
        if (m_pos == 9) begin
            push(EV_ACK, v);
            m_pos = 0; m_byte = 0;
        end
    endfunction

    task automatic mon_check(input ev_kind_t k, input logic [7:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(int'(k) * 256) | 32'(v), 32'hFFFF_FFFF);
            return;
        end
        e = exp_q.pop_front();
        chk("event(kind*256+val)", 32'(int'(k) * 256) | 32'(v), 32'(int'(e.kind) * 256) | 32'(e.val));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.start_det) mon_check(EV_START, {7'b0, bus.bus_err});
            if (bus.stop_det)  mon_check(EV_STOP,  {7'b0, bus.bus_err});
            if (bus.rx_valid)  mon_check(EV_BYTE,  bus.rx_byte);
            if (bus.ack_valid) mon_check(EV_ACK,   {7'b0, bus.rx_ack});
            if (bus.bus_err && !bus.start_det && !bus.stop_det) chk("stray_bus_err", 32'd1, 32'd0);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ends with SCL high so the next operation may be a strobe.
    task automatic clk_bit(input bit v);
        if (bus.scl_in) begin
            bus.scl_in = 1'b0;
            wait_clk(H);
        end
        bus.sda_in = v;
        wait_clk(H);
        m_bit(int'(v));
        bus.scl_in = 1'b1;
        wait_clk(H);
    endtask

    task automatic toggle_sda();
        if (!bus.scl_in) clk_bit(bus.sda_in);
        if (bus.sda_in) m_start(); else m_stop();
        bus.sda_in = ~bus.sda_in;
        wait_clk(H);
    endtask

    task automatic coincident(input bit v);
        if (bus.scl_in) begin
            bus.scl_in = 1'b0;
            bus.sda_in = ~bus.sda_in;
            wait_clk(H);
        end
        m_bit(int'(v));
        bus.scl_in = 1'b1;
        bus.sda_in = v;
        wait_clk(H);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) clk_bit(b[i]);
    endtask

    int lat;

    initial begin
        rst = 1'b0;
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.scl_in = ~bus.scl_in;
            bus.sda_in = (i % 2 == 0);
        end
        @(negedge clk);
        chk("rst_scl", 32'(bus.scl), 32'd1);
        chk("rst_sda", 32'(bus.sda), 32'd1);
        chk("rst_pulses", {26'd0, bus.scl_rise, bus.scl_fall, bus.start_det, bus.stop_det, bus.rx_valid, bus.ack_valid}, 32'd0);
        chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
        chk("rst_bus_busy", 32'(bus.bus_busy), 32'd0);
        chk("rst_rx_byte", 32'(bus.rx_byte), 32'h00);
        chk("rst_rx_ack", 32'(bus.rx_ack), 32'd1);
        chk("rst_ack_slot", 32'(bus.ack_slot), 32'd0);
        chk("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        wait_clk(2);
        rst = 1'b1;
        mon_en = 1'b1;
        wait_clk(2 * H);

        // Two-clock SDA glitch under high SCL.
        if (SHORT_PASSES) m_start();
        bus.sda_in = 1'b0;
        wait_clk(2);
        if (SHORT_PASSES) m_stop();
        bus.sda_in = 1'b1;
        wait_clk(3 * H);
        chk("glitch_bus_busy", 32'(bus.bus_busy), 32'd0);

        // Three-clock pulse: START latency from the pin edge, then STOP on release.
        @(negedge clk);
        m_start();
        bus.sda_in = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.start_det) lat = k;
            if (k == 3) begin
                m_stop();
                bus.sda_in = 1'b1;
            end
        end
        if (!bus.sda_in) begin
            m_stop();
            bus.sda_in = 1'b1;
        end
        chk("start_latency", 32'(lat), 32'(START_LAT));
        wait_clk(3 * H);

        // Write frame, repeated START after a NACKed byte, then STOP.
        toggle_sda();
        chk("frame_busy", 32'(bus.bus_busy), 32'd1);
        send_byte(8'hA4);
        chk("ack_slot_open", 32'(bus.ack_slot), 32'd1);
        chk("bit_cnt_full", 32'(bus.bit_cnt), 32'd8);
        clk_bit(1'b0);
        chk("ack_slot_closed", 32'(bus.ack_slot), 32'd0);
        chk("bit_cnt_after_ack", 32'(bus.bit_cnt), 32'd0);
        send_byte(8'h5B);
        clk_bit(1'b1);
        toggle_sda();
        chk("rstart_busy", 32'(bus.bus_busy), 32'd1);
        chk("rstart_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        toggle_sda();
        chk("stop_busy", 32'(bus.bus_busy), 32'd0);

        // STOP after three data bits.
        toggle_sda();
        clk_bit(1'b1);
        clk_bit(1'b1);
        clk_bit(1'b0);
        chk("partial_bit_cnt", 32'(bus.bit_cnt), 32'd3);
        toggle_sda();
        chk("abort_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("abort_busy", 32'(bus.bus_busy), 32'd0);

        // Simultaneous SCL/SDA changes produce no strobes.
        coincident(1'b0);
        coincident(1'b1);
        chk("coincident_busy", 32'(bus.bus_busy), 32'd0);

        // Reset in mid-frame discards the partial byte silently.
        toggle_sda();
        clk_bit(1'b1);
        clk_bit(1'b0);
        clk_bit(1'b1);
        rst = 1'b0;
        wait_clk(2);
        rst = 1'b1;
        m_busy = 1'b0; m_pos = 0; m_byte = 0;
        wait_clk(H);
        chk("midrst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("midrst_busy", 32'(bus.bus_busy), 32'd0);

        // Random bus traffic.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0)      toggle_sda();
            else if (r == 1) coincident(1'($urandom_range(0, 1)));
            else             clk_bit(1'($urandom_range(0, 1)));
        end

        wait_clk(4 * H);
        chk("leftover_events", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
